branch_predict_unit: RTL and testbench

//  Parametrised successor of the single-cycle branch resolver: adds a direct-mapped branch

---
 rtl/branch_predict_unit_pkg.sv | 45 ++++
 rtl/branch_predict_unit_table.sv | 73 +++++++
 rtl/branch_predict_unit.sv | 128 ++++++++++++
 tb/tb_branch_predict_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
//   Shared types and helpers for the branch prediction unit.
//   ctr_t        : 2-bit saturating direction counter
//   CTR_*        : counter encodings (strongly/weakly not-taken/taken)
//   bpu_entry_t  : width-independent part of a table entry (the tag is
//                  stored alongside it because its width depends on the
//                  PC width and the table depth)
//   ctr_next     : saturating counter step
// ---------------------------------------------------------------------------
package branch_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef struct packed {
    logic        valid;
    logic        is_jump;
    ctr_t        ctr;
    logic [31:0] target;
  } bpu_entry_t;

  localparam bpu_entry_t ENTRY_RESET = '{
    valid:   1'b0,
    is_jump: 1'b0,
    ctr:     CTR_WNT,
    target:  32'h0000_0000
  };

  // Saturating increment on taken, saturating decrement on not taken.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    if (taken) begin
      n = (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    end else begin
      n = (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_table.sv
// ---------------------------------------------------------------------------
// bpu_table
//   Direct-mapped branch history / target table.
//   clk, reset    : clock; synchronous active-high clear of every entry
//   rd_idx        : asynchronous read index (fetch lookup)
//   rd_entry      : entry at rd_idx
//   rd_tag        : tag stored at rd_idx
//   wr_en         : write the resolved outcome into wr_idx on the clock edge
//   wr_idx/wr_tag : location and tag of the resolving instruction
//   wr_taken      : resolved direction
//   wr_is_jump    : resolving instruction is an unconditional jump
//   wr_target     : resolved taken target
//   The counter update is a read-modify-write of the entry being written:
//   a tag hit steps the existing counter, a miss re-initialises it.
//   Reads return the pre-write contents (no write-to-read bypass).
// ---------------------------------------------------------------------------
module bpu_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bpu_entry_t       rd_entry,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic             wr_is_jump,
  input  logic [31:0]      wr_target
);

  bpu_entry_t       entry_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];

  bpu_entry_t old_entry;
  logic       wr_hit;
  bpu_entry_t new_entry;

  assign rd_entry = entry_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

  always_comb begin
    old_entry         = entry_q[wr_idx];
    wr_hit            = old_entry.valid && (tag_q[wr_idx] == wr_tag);
    new_entry.valid   = 1'b1;
    new_entry.is_jump = wr_is_jump;
    new_entry.target  = wr_target;
    if (wr_hit) begin
      new_entry.ctr = ctr_next(old_entry.ctr, wr_taken);
    end else begin
      new_entry.ctr = wr_taken ? CTR_WT : CTR_WNT;
    end
  end

  // Reset has priority over a same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= ENTRY_RESET;
        tag_q[i]   <= '0;
      end
    end else if (wr_en) begin
      entry_q[wr_idx] <= new_entry;
      tag_q[wr_idx]   <= wr_tag;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Fetch-time branch prediction plus EX-stage resolution.
//   clk, reset      : clock; synchronous active-high reset
//   f_pc            : fetch PC
//   f_pred_taken    : prediction for f_pc (combinational)
//   f_pred_target   : predicted next PC (f_pc+4 when not taken)
//   ex_valid        : EX holds a valid instruction
//   ex_pc, ex_imm   : PC and immediate of the EX instruction
//   ex_alu_result   : bit 0 is the branch condition
//   ex_branch       : conditional branch
//   ex_jump         : unconditional PC-relative jump (wins over ex_branch)
//   ex_pred_taken   : prediction carried with the instruction
//   ex_pred_target  : predicted target carried with the instruction
//   ex_pc_four      : ex_pc+4 (link value)
//   ex_pc_imm       : ex_pc+ex_imm
//   redirect        : mispredict, flush younger stages and load redirect_pc
//   redirect_pc     : correct next PC
//   perf_branches   : resolved branch/jump count (saturating)
//   perf_mispred    : redirect count (saturating)
// ---------------------------------------------------------------------------
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_WIDTH   = 9,
  parameter int ENTRIES    = 16,
  parameter int PREDICT_EN = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  f_pc,
  output logic                 f_pred_taken,
  output logic [31:0]          f_pred_target,
  input  logic                 ex_valid,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [31:0]          ex_imm,
  input  logic [31:0]          ex_alu_result,
  input  logic                 ex_branch,
  input  logic                 ex_jump,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  output logic [31:0]          ex_pc_four,
  output logic [31:0]          ex_pc_imm,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] perf_branches,
  output logic [CNT_WIDTH-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  // ---------------- fetch lookup ----------------
  logic [31:0]      f_pc_ext;
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  bpu_entry_t       f_entry;
  logic [TAG_W-1:0] f_entry_tag;
  logic             f_hit;

  assign f_pc_ext = 32'(f_pc);
  assign f_idx    = f_pc[IDX_W+1:2];
  assign f_tag    = f_pc[PC_WIDTH-1:IDX_W+2];
  assign f_hit    = f_entry.valid && (f_entry_tag == f_tag);

  // Jumps are always predicted taken on a hit; branches use the counter MSB.
  assign f_pred_taken  = (PREDICT_EN != 0) && f_hit && (f_entry.is_jump || f_entry.ctr[1]);
  assign f_pred_target = f_pred_taken ? f_entry.target : f_pc_ext + 32'd4;

  // ---------------- EX resolve ----------------
  logic [31:0]      ex_pc_ext;
  logic             act_taken;
  logic             resolve;
  logic             tbl_wr_en;

  assign ex_pc_ext   = 32'(ex_pc);
  assign ex_pc_four  = ex_pc_ext + 32'd4;
  assign ex_pc_imm   = ex_pc_ext + ex_imm;
  assign act_taken   = (ex_branch && ex_alu_result[0]) || ex_jump;
  assign redirect_pc = act_taken ? ex_pc_imm : ex_pc_four;

  // A non-branch that was predicted taken (stale alias) also redirects, to pc+4.
  assign redirect = ex_valid &&
                    ((ex_pred_taken != act_taken) ||
                     (act_taken && (ex_pred_target != ex_pc_imm)));

  assign resolve   = ex_valid && (ex_branch || ex_jump);
  assign tbl_wr_en = resolve && (PREDICT_EN != 0);

  bpu_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (f_idx),
    .rd_entry   (f_entry),
    .rd_tag     (f_entry_tag),
    .wr_en      (tbl_wr_en),
    .wr_idx     (ex_pc[IDX_W+1:2]),
    .wr_tag     (ex_pc[PC_WIDTH-1:IDX_W+2]),
    .wr_taken   (act_taken),
    .wr_is_jump (ex_jump),
    .wr_target  (ex_pc_imm)
  );

  // ---------------- performance counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (resolve && (perf_branches != '1)) begin
        perf_branches <= perf_branches + CNT_WIDTH'(1);
      end
      if (redirect && (perf_mispred != '1)) begin
        perf_mispred <= perf_mispred + CNT_WIDTH'(1);
      end
    end
  end

  // Only the condition bit of the ALU result and the counter MSB matter here.
  logic unused_bits;
  assign unused_bits = ^{ex_alu_result[31:1], f_entry.ctr[0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  f_pc;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_result;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        ft0, ft1;
  logic [31:0] ftgt0, ftgt1;
  logic [31:0] p4_0, p4_1, pi_0, pi_1;
  logic        red0, red1;
  logic [31:0] rpc0, rpc1;
  logic [31:0] pb0, pb1, pm0, pm1;

  always #5 clk = ~clk;

  branch_predict_unit #(.PC_WIDTH(9), .ENTRIES(16), .PREDICT_EN(1), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(ft0), .f_pred_target(ftgt0),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_pc_four(p4_0), .ex_pc_imm(pi_0),
    .redirect(red0), .redirect_pc(rpc0), .perf_branches(pb0), .perf_mispred(pm0)
  );

  branch_predict_unit #(.PC_WIDTH(9), .ENTRIES(16), .PREDICT_EN(0), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(ft1), .f_pred_target(ftgt1),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_pc_four(p4_1), .ex_pc_imm(pi_1),
    .redirect(red1), .redirect_pc(rpc1), .perf_branches(pb1), .perf_mispred(pm1)
  );

  typedef enum int {K_FT, K_FTGT, K_RED, K_RPC, K_P4, K_PI, K_PB, K_PM,
                    K_FT1, K_FTGT1, K_RED1, K_PB1, K_PM1} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(kind_t k);
    logic [31:0] a;
    case (k)
      K_FT:    a = {31'b0, ft0};
      K_FTGT:  a = ftgt0;
      K_RED:   a = {31'b0, red0};
      K_RPC:   a = rpc0;
      K_P4:    a = p4_0;
      K_PI:    a = pi_0;
      K_PB:    a = pb0;
      K_PM:    a = pm0;
      K_FT1:   a = {31'b0, ft1};
      K_FTGT1: a = ftgt1;
      K_RED1:  a = {31'b0, red1};
      K_PB1:   a = pb1;
      K_PM1:   a = pm1;
      default: a = 32'hDEAD_BEEF;
    endcase
    return a;
  endfunction

  // Monitor: compares every pending expectation mid-cycle, away from the edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(kind_t k, logic [31:0] v, string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic fexp(logic t, logic [31:0] tgt, string n);
    expect_v(K_FT, {31'b0, t}, {n, "_f_pred_taken"});
    expect_v(K_FTGT, tgt, {n, "_f_pred_target"});
  endtask

  task automatic pexp(int b, int m, string n);
    expect_v(K_PB, 32'(b), {n, "_perf_branches"});
    expect_v(K_PM, 32'(m), {n, "_perf_mispred"});
  endtask

  task automatic rexp(logic r, logic [31:0] pc, string n);
    expect_v(K_RED, {31'b0, r}, {n, "_redirect"});
    if (r) expect_v(K_RPC, pc, {n, "_redirect_pc"});
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_pc = '0; ex_imm = '0;
    ex_alu_result = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic ex_drive(logic v, logic br, logic j, logic [8:0] pc, logic [31:0] imm,
                          logic cond, logic pt, logic [31:0] ptgt);
    ex_valid = v; ex_branch = br; ex_jump = j; ex_pc = pc; ex_imm = imm;
    ex_alu_result = {31'b0, cond}; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  initial begin
    reset = 1'b1;
    f_pc  = 9'h000;
    ex_idle();
    step();
    step();

    // Out of reset: no prediction, counters clear
    reset = 1'b0;
    f_pc  = 9'h040;
    fexp(0, 32'h044, "rst");
    pexp(0, 0, "rst");
    rexp(0, 0, "rst");

    // beq at 0x040 taken backwards, predicted not taken
    step();
    ex_drive(1, 1, 0, 9'h040, 32'hFFFF_FFF0, 1, 0, 32'h044);
    rexp(1, 32'h030, "beq1");
    expect_v(K_P4, 32'h044, "beq1_pc_four");
    expect_v(K_PI, 32'h030, "beq1_pc_imm");
    expect_v(K_RED1, 32'h1, "beq1_redirect_noepred");
    fexp(0, 32'h044, "beq1_prewrite");
    pexp(0, 0, "beq1");

    // Table now predicts taken (ctr 10)
    step();
    ex_idle();
    fexp(1, 32'h030, "beq1_after");
    rexp(0, 0, "idle1");
    pexp(1, 1, "beq1_after");
    expect_v(K_FT1, 32'h0, "nopred_taken");
    expect_v(K_FTGT1, 32'h044, "nopred_target");
    expect_v(K_PB1, 32'h1, "nopred_perf_branches");
    expect_v(K_PM1, 32'h1, "nopred_perf_mispred");

    // Not taken while predicted taken: ctr 10 -> 01
    step();
    ex_drive(1, 1, 0, 9'h040, 32'hFFFF_FFF0, 0, 1, 32'h030);
    rexp(1, 32'h044, "nt1");
    fexp(1, 32'h030, "nt1");

    // Not taken again, now predicted not taken: ctr 01 -> 00
    step();
    ex_drive(1, 1, 0, 9'h040, 32'hFFFF_FFF0, 0, 0, 32'h044);
    fexp(0, 32'h044, "nt2");
    rexp(0, 0, "nt2");
    pexp(2, 2, "nt2");

    // Taken once from 00 -> 01 must still predict not taken
    step();
    ex_drive(1, 1, 0, 9'h040, 32'hFFFF_FFF0, 1, 0, 32'h044);
    fexp(0, 32'h044, "ctr00");
    rexp(1, 32'h030, "ctr00");
    pexp(3, 2, "ctr00");

    step();
    ex_idle();
    fexp(0, 32'h044, "ctr01");
    pexp(4, 3, "ctr01");

    // New branch at 0x0C4: miss, taken -> ctr 10
    step();
    ex_drive(1, 1, 0, 9'h0C4, 32'h20, 1, 0, 32'h0C8);
    f_pc = 9'h0C4;
    fexp(0, 32'h0C8, "b2_miss");
    rexp(1, 32'h0E4, "b2_first");

    // Correctly predicted taken four times: ctr saturates at 11
    for (int i = 0; i < 4; i++) begin
      step();
      ex_drive(1, 1, 0, 9'h0C4, 32'h20, 1, 1, 32'h0E4);
      fexp(1, 32'h0E4, "b2_sat");
      rexp(0, 0, "b2_sat");
      pexp(5 + i, 4, "b2_sat");
    end

    // One not-taken from 11 leaves 10, still taken
    step();
    ex_drive(1, 1, 0, 9'h0C4, 32'h20, 0, 1, 32'h0E4);
    rexp(1, 32'h0C8, "b2_nt");
    pexp(9, 4, "b2_nt");

    step();
    ex_idle();
    fexp(1, 32'h0E4, "b2_ctr10");
    pexp(10, 5, "b2_ctr10");

    // JAL at 0x1FC
    step();
    ex_drive(1, 0, 1, 9'h1FC, 32'h8, 0, 0, 32'h200);
    f_pc = 9'h1FC;
    rexp(1, 32'h204, "jal");
    expect_v(K_P4, 32'h200, "jal_pc_four");
    expect_v(K_PI, 32'h204, "jal_pc_imm");
    fexp(0, 32'h200, "jal_miss");

    step();
    ex_idle();
    fexp(1, 32'h204, "jal_hit");
    expect_v(K_FT1, 32'h0, "nopred_jal_taken");
    expect_v(K_FTGT1, 32'h200, "nopred_jal_target");
    pexp(11, 6, "jal_after");

    // Alias at 0x03C (same index, different tag) plus an invalid EX slot
    step();
    ex_drive(0, 1, 0, 9'h03C, 32'h40, 1, 0, 32'h040);
    f_pc = 9'h03C;
    fexp(0, 32'h040, "alias");
    rexp(0, 0, "exinv");
    expect_v(K_RED1, 32'h0, "exinv_redirect1");
    expect_v(K_PI, 32'h07C, "exinv_pc_imm");

    step();
    ex_idle();
    fexp(0, 32'h040, "exinv_noupd");
    pexp(11, 6, "exinv_nocount");

    // Stale alias: non-branch predicted taken goes to pc+4, no table update
    step();
    ex_drive(1, 0, 0, 9'h0C4, 32'h20, 1, 1, 32'h0E4);
    f_pc = 9'h0C4;
    rexp(1, 32'h0C8, "stale");
    fexp(1, 32'h0E4, "stale");

    step();
    ex_idle();
    fexp(1, 32'h0E4, "stale_noupd");
    pexp(11, 7, "stale_after");

    // Taken with wrong predicted target
    step();
    ex_drive(1, 1, 0, 9'h0C4, 32'h20, 1, 1, 32'h100);
    rexp(1, 32'h0E4, "badtgt");

    // Reset concurrent with an update: reset wins
    step();
    reset = 1'b1;
    ex_drive(1, 1, 0, 9'h0C4, 32'h20, 0, 1, 32'h0E4);
    rexp(1, 32'h0C8, "rst_upd");
    pexp(12, 8, "rst_upd");

    step();
    reset = 1'b0;
    ex_idle();
    fexp(0, 32'h0C8, "post_rst");
    pexp(0, 0, "post_rst");
    expect_v(K_FT1, 32'h0, "nopred_post_rst_taken");
    expect_v(K_FTGT1, 32'h0C8, "nopred_post_rst_target");
    expect_v(K_PB1, 32'h0, "nopred_post_rst_perf_branches");
    expect_v(K_PM1, 32'h0, "nopred_post_rst_perf_mispred");

    // Let the monitor drain, with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
